pe_array_ctrl: RTL and testbench
================================

# pe_array_ctrl

Sequencer for a ROWS×COLS systolic array of 2-stage floating-point multiply-accumulate processing elements. The block does four things for each tile:
- clears the array;
- streams skewed read enables and addresses to the A (west) and B (north) operand buffers;
- pulses each PE's in_done_flag at the cycle its two partial sums must merge;
- pulses a per-PE result strobe when that PE's out_c holds the final dot product.

It sits between the tile scheduler (start/done handshake) and the array plus its operand and result buffers.

## Interface
- ROWS, 4, array rows
- COLS, 4, array columns
- K_W, 8, width of k_len
- ADDR_W, 8, operand buffer address width (≥ K_W)
- PIPE_STAGE, 2, PE multiplier/adder pipeline depth
- DONE_OFS, 2*PIPE_STAGE, cycles from a PE's last operand to its in_done_flag
- RES_OFS, PIPE_STAGE+1, cycles from in_done_flag to final out_c
---
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  tile request; sampled only in IDLE
- k_len  in  K_W  inner-product length K; captured on accepted start
- simd_mode  in  2  captured on accepted start
- abort  in  1  cancel the current tile
- busy  out  1  high from accepted start until done/abort completes
- done  out  1  one-cycle pulse: tile complete
- aborted  out  1  one-cycle pulse: abort complete
- err  out  1  one-cycle pulse: start rejected
- pe_reset  out  1  synchronous active-high clear to all PEs
- SIMD_control  out  2  registered simd_mode, held through the tile
- a_rd_en  out  ROWS  per-row A buffer read enable
- a_rd_addr  out  ROWS*ADDR_W  per-row A address, row r at [r*ADDR_W +: ADDR_W]
- b_rd_en  out  COLS  per-column B buffer read enable
- b_rd_addr  out  COLS*ADDR_W  per-column B address
- done_flag  out  ROWS*COLS  in_done_flag per PE, index r*COLS+c
- res_valid  out  ROWS*COLS  result capture strobe per PE

## Operation
- States:
  - IDLE
  - CLEAR: 2 cycles
  - RUN
  - FLUSH: 2 cycles, abort path only
- IDLE:
  - start with k_len ≥ 2: capture K and simd_mode, go to CLEAR.
  - start with k_len < 2: err pulse next cycle, stay in IDLE.
- CLEAR:
  - pe_reset=1, all enables 0.
  - Then go to RUN, with cycle counter t=0.
- RUN: t increments each cycle. Let d = r+c.
  - a_rd_en[r]=1 iff r ≤ t ≤ r+K−1; a_rd_addr[r]=t−r while enabled, else 0.
  - b_rd_en[c] and b_rd_addr[c]: same rule with c in place of r.
  - done_flag[r*COLS+c]=1 only at t = d+K+DONE_OFS.
  - res_valid[r*COLS+c]=1 only at t = d+K+DONE_OFS+RES_OFS.
  - At t = T_END = ROWS+COLS−2+K+DONE_OFS+RES_OFS: on the next edge go to IDLE with done=1 and busy=0 in that same cycle.
- abort in CLEAR or RUN (ignored in IDLE/FLUSH):
  - Next cycle: all enables, done_flag and res_valid = 0.
  - FLUSH with pe_reset=1 for 2 cycles, then IDLE with aborted=1.
  - No done pulse.
- start while busy: ignored, no err.
- abort and done on the same edge (abort at t=T_END): abort wins.
- No stall input; the PE pipelines are free-running.
- Reset values:
  - state IDLE, t=0.
  - All outputs 0, including pe_reset and SIMD_control.

## Timing
- Start to first a_rd_en[0]: 3 cycles (accept edge, 2 CLEAR cycles).
- Buffer read latency is 1 cycle; PE(r,c) receives its first operand pair at t=d+1.
- The t counter is wide enough for ROWS+COLS+2^K_W+DONE_OFS+RES_OFS; no wrap inside a tile.
- All outputs are registered.

## Configuration
- ARRAY_CTRL_PERF_EN defined:
  - Adds output tile_cnt[31:0], which increments on each done.
  - Adds output busy_cycles[31:0], which increments on every busy cycle.
  - Both reset to 0 via rst_n and saturate at all-ones.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Package array_ctrl_pkg holds:
  - the state enum (IDLE, CLEAR, RUN, FLUSH);
  - CLEAR_CYCLES=2 and FLUSH_CYCLES=2;
  - a function computing T_END from ROWS, COLS, K, DONE_OFS and RES_OFS.
- One sub-module, skew_window.
  - Given t, index i and K, it produces enable and address for one row or column.
  - It is instantiated ROWS+COLS times.
- done_flag and res_valid decode lives in the top level.

## Test plan
Settings: ROWS=COLS=4, PIPE_STAGE=2 (DONE_OFS=4, RES_OFS=3).
- Reset: hold rst_n=0 mid-RUN → all outputs 0 asynchronously; after release, state is IDLE.
- k_len=8:
  - busy high for exactly 24 cycles;
  - done pulses once at t=22;
  - a_rd_en[3] high for t=3..10 with addr 0..7;
  - done_flag[0] at t=12, done_flag[15] at t=18;
  - res_valid[15] at t=21.
- k_len=1 → err pulse, busy stays 0; then k_len=2 → done when t reaches T_END=15.
- Second start during RUN → ignored; the first tile's timing is unchanged.
- abort at t=5 → enables 0 at t=6, pe_reset high 2 cycles, aborted pulse, no done, no res_valid.
- Two back-to-back tiles with simd_mode=2 then 1 → SIMD_control follows per tile; with ARRAY_CTRL_PERF_EN, tile_cnt=2.

Source files
------------

// File: rtl/array_ctrl_pkg.sv
// Shared types and timing helpers for the PE array sequencer.
package array_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam int CLEAR_CYCLES = 2;
    localparam int FLUSH_CYCLES = 2;

    // Last RUN cycle: the far-corner PE's result strobe.
    function automatic int calc_t_end(input int rows, input int cols, input int k,
                                      input int done_ofs, input int res_ofs);
        return rows + cols - 2 + k + done_ofs + res_ofs;
    endfunction

endpackage

// File: rtl/pe_array_ctrl_skew_window.sv
// Skewed read window for one array row or column: enabled for K cycles starting at t=IDX.
module skew_window
    import array_ctrl_pkg::*;
#(
    parameter int T_W    = 10,
    parameter int K_W    = 8,
    parameter int ADDR_W = 8,
    parameter int IDX    = 0
) (
    input  logic [T_W-1:0]    t,
    input  logic [K_W-1:0]    k,
    output logic              en,
    output logic [ADDR_W-1:0] addr
);

    logic [T_W-1:0] lo;
    logic [T_W-1:0] hi;
    logic [T_W-1:0] ofs;

    assign lo   = T_W'(IDX);
    assign hi   = lo + T_W'(k);  // exclusive upper bound
    assign ofs  = t - lo;
    assign en   = (t >= lo) && (t < hi);
    assign addr = en ? ADDR_W'(ofs) : '0;

endmodule

// File: rtl/pe_array_ctrl.sv
// Tile sequencer for a ROWS x COLS systolic MAC array.
// Optional ARRAY_CTRL_PERF_EN adds tile_cnt / busy_cycles performance counters.
module pe_array_ctrl
    import array_ctrl_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int K_W        = 8,
    parameter int ADDR_W     = 8,
    parameter int PIPE_STAGE = 2,
    parameter int DONE_OFS   = 2 * PIPE_STAGE,
    parameter int RES_OFS    = PIPE_STAGE + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [K_W-1:0]         k_len,
    input  logic [1:0]             simd_mode,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic                   err,
    output logic                   pe_reset,
    output logic [1:0]             SIMD_control,
    output logic [ROWS-1:0]        a_rd_en,
    output logic [ROWS*ADDR_W-1:0] a_rd_addr,
    output logic [COLS-1:0]        b_rd_en,
    output logic [COLS*ADDR_W-1:0] b_rd_addr,
    output logic [ROWS*COLS-1:0]   done_flag,
    output logic [ROWS*COLS-1:0]   res_valid
`ifdef ARRAY_CTRL_PERF_EN
    ,
    output logic [31:0]            tile_cnt,
    output logic [31:0]            busy_cycles
`endif
);

    localparam int T_W = $clog2(ROWS + COLS + (1 << K_W) + DONE_OFS + RES_OFS + 1);

    state_t         state, state_nxt;
    logic [T_W-1:0] t, t_nxt, t_end;
    logic [K_W-1:0] k_q;
    logic           accept, reject, fin, flush_end, run_nxt;

    assign t_end     = T_W'(calc_t_end(ROWS, COLS, int'(k_q), DONE_OFS, RES_OFS));
    assign accept    = (state == IDLE) && start && (k_len >= K_W'(2));
    assign reject    = (state == IDLE) && start && (k_len < K_W'(2));
    assign fin       = (state == RUN) && !abort && (t == t_end);
    assign flush_end = (state == FLUSH) && (t == T_W'(FLUSH_CYCLES - 1));
    assign run_nxt   = (state_nxt == RUN);

    // t doubles as the phase counter in CLEAR and FLUSH.
    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = CLEAR;
                    t_nxt     = '0;
                end
            end
            CLEAR: begin
                if (abort) begin
                    state_nxt = FLUSH;
                    t_nxt     = '0;
                end else if (t == T_W'(CLEAR_CYCLES - 1)) begin
                    state_nxt = RUN;
                    t_nxt     = '0;
                end else begin
                    t_nxt = t + T_W'(1);
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = FLUSH;
                    t_nxt     = '0;
                end else if (t == t_end) begin
                    state_nxt = IDLE;
                    t_nxt     = '0;
                end else begin
                    t_nxt = t + T_W'(1);
                end
            end
            FLUSH: begin
                if (flush_end) begin
                    state_nxt = IDLE;
                    t_nxt     = '0;
                end else begin
                    t_nxt = t + T_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                t_nxt     = '0;
            end
        endcase
    end

    // Windows are evaluated on next-state t so the registered outputs line up with t.
    logic [ROWS-1:0]             a_en_w;
    logic [ROWS-1:0][ADDR_W-1:0] a_addr_w;
    logic [COLS-1:0]             b_en_w;
    logic [COLS-1:0][ADDR_W-1:0] b_addr_w;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        skew_window #(.T_W(T_W), .K_W(K_W), .ADDR_W(ADDR_W), .IDX(r)) u_win (
            .t(t_nxt), .k(k_q), .en(a_en_w[r]), .addr(a_addr_w[r])
        );
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        skew_window #(.T_W(T_W), .K_W(K_W), .ADDR_W(ADDR_W), .IDX(c)) u_win (
            .t(t_nxt), .k(k_q), .en(b_en_w[c]), .addr(b_addr_w[c])
        );
    end

    logic [ROWS*COLS-1:0] dflag_w, rvalid_w;

    always_comb begin
        dflag_w  = '0;
        rvalid_w = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (t_nxt == T_W'(r + c + DONE_OFS) + T_W'(k_q))
                    dflag_w[r*COLS+c] = 1'b1;
                if (t_nxt == T_W'(r + c + DONE_OFS + RES_OFS) + T_W'(k_q))
                    rvalid_w[r*COLS+c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            t            <= '0;
            k_q          <= '0;
            SIMD_control <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            err          <= 1'b0;
            pe_reset     <= 1'b0;
            a_rd_en      <= '0;
            a_rd_addr    <= '0;
            b_rd_en      <= '0;
            b_rd_addr    <= '0;
            done_flag    <= '0;
            res_valid    <= '0;
        end else begin
            state <= state_nxt;
            t     <= t_nxt;
            if (accept) begin
                k_q          <= k_len;
                SIMD_control <= simd_mode;
            end
            busy      <= (state_nxt != IDLE);
            done      <= fin;
            aborted   <= flush_end;
            err       <= reject;
            pe_reset  <= (state_nxt == CLEAR) || (state_nxt == FLUSH);
            a_rd_en   <= run_nxt ? a_en_w   : '0;
            a_rd_addr <= run_nxt ? a_addr_w : '0;
            b_rd_en   <= run_nxt ? b_en_w   : '0;
            b_rd_addr <= run_nxt ? b_addr_w : '0;
            done_flag <= run_nxt ? dflag_w  : '0;
            res_valid <= run_nxt ? rvalid_w : '0;
        end
    end

`ifdef ARRAY_CTRL_PERF_EN
    // tile_cnt steps with the done pulse itself; both counters saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_cnt    <= '0;
            busy_cycles <= '0;
        end else begin
            if (fin && (tile_cnt != '1))
                tile_cnt <= tile_cnt + 32'd1;
            if (busy && (busy_cycles != '1))
                busy_cycles <= busy_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Scoreboard bench for pe_array_ctrl: randomized tiles against a per-cycle reference schedule.
module tb_pe_array_ctrl;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int K_W      = 8;
    localparam int ADDR_W   = 8;
    localparam int DONE_OFS = 4;
    localparam int RES_OFS  = 3;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start, abort;
    logic [K_W-1:0]         k_len;
    logic [1:0]             simd_mode;
    logic                   busy, done, aborted, err, pe_reset;
    logic [1:0]             SIMD_control;
    logic [ROWS-1:0]        a_rd_en;
    logic [ROWS*ADDR_W-1:0] a_rd_addr;
    logic [COLS-1:0]        b_rd_en;
    logic [COLS*ADDR_W-1:0] b_rd_addr;
    logic [ROWS*COLS-1:0]   done_flag, res_valid;
`ifdef ARRAY_CTRL_PERF_EN
    logic [31:0]            tile_cnt, busy_cycles;
`endif

    pe_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W), .ADDR_W(ADDR_W), .PIPE_STAGE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .simd_mode(simd_mode),
        .abort(abort), .busy(busy), .done(done), .aborted(aborted), .err(err),
        .pe_reset(pe_reset), .SIMD_control(SIMD_control),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr),
        .done_flag(done_flag), .res_valid(res_valid)
`ifdef ARRAY_CTRL_PERF_EN
        , .tile_cnt(tile_cnt), .busy_cycles(busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic                   busy, done, aborted, err, pe_reset;
        logic [1:0]             simd;
        logic [ROWS-1:0]        a_en;
        logic [ROWS*ADDR_W-1:0] a_addr;
        logic [COLS-1:0]        b_en;
        logic [COLS*ADDR_W-1:0] b_addr;
        logic [ROWS*COLS-1:0]   dflag, rvalid;
    } frame_t;

    typedef struct {
        int kind;  // 0 done, 1 aborted, 2 err
        int cyc;
    } ev_t;

    frame_t   exp_fr [int];
    ev_t      evq [$];
    int       free_cyc = 0;
    logic [1:0] m_simd = '0;
    bit       finish_req = 1'b0;

    int checks, errors, exp_busy_cnt, exp_done_cnt;
    logic [1:0] last_simd;

    function automatic frame_t sample();
        frame_t f;
        f.busy = busy;       f.done = done;         f.aborted = aborted;
        f.err = err;         f.pe_reset = pe_reset; f.simd = SIMD_control;
        f.a_en = a_rd_en;    f.a_addr = a_rd_addr;
        f.b_en = b_rd_en;    f.b_addr = b_rd_addr;
        f.dflag = done_flag; f.rvalid = res_valid;
        return f;
    endfunction

    // Reference schedule for a start issued in cycle n; abort_off>0 means abort driven in cycle n+abort_off.
    function automatic void plan(input int n, input int k, input int simd, input int abort_off);
        frame_t f;
        ev_t    ev;
        int     tend, last, t, d;
        if (k < 2) begin
            f = '0; f.err = 1'b1; f.simd = m_simd;
            exp_fr[n+1] = f;
            ev.kind = 2; ev.cyc = n + 1; evq.push_back(ev);
            free_cyc = n + 1;
            return;
        end
        m_simd = 2'(simd);
        tend = ROWS + COLS - 2 + k + DONE_OFS + RES_OFS;
        last = (abort_off > 0) ? n + abort_off : n + 3 + tend;
        for (int c = n + 1; c <= last; c++) begin
            f = '0; f.busy = 1'b1; f.simd = m_simd;
            t = c - n - 3;
            if (t < 0) begin
                f.pe_reset = 1'b1;
            end else begin
                for (int r = 0; r < ROWS; r++)
                    if (t >= r && t <= r + k - 1) begin
                        f.a_en[r] = 1'b1;
                        f.a_addr[r*ADDR_W +: ADDR_W] = ADDR_W'(t - r);
                    end
                for (int q = 0; q < COLS; q++)
                    if (t >= q && t <= q + k - 1) begin
                        f.b_en[q] = 1'b1;
                        f.b_addr[q*ADDR_W +: ADDR_W] = ADDR_W'(t - q);
                    end
                for (int r = 0; r < ROWS; r++)
                    for (int q = 0; q < COLS; q++) begin
                        d = r + q;
                        if (t == d + k + DONE_OFS)           f.dflag[r*COLS+q]  = 1'b1;
                        if (t == d + k + DONE_OFS + RES_OFS) f.rvalid[r*COLS+q] = 1'b1;
                    end
            end
            exp_fr[c] = f;
        end
        if (abort_off > 0) begin
            for (int c = last + 1; c <= last + 2; c++) begin
                f = '0; f.busy = 1'b1; f.pe_reset = 1'b1; f.simd = m_simd;
                exp_fr[c] = f;
            end
            f = '0; f.aborted = 1'b1; f.simd = m_simd;
            exp_fr[last+3] = f;
            ev.kind = 1; ev.cyc = last + 3; evq.push_back(ev);
            free_cyc = last + 3;
        end else begin
            f = '0; f.done = 1'b1; f.simd = m_simd;
            exp_fr[last+1] = f;
            ev.kind = 0; ev.cyc = last + 1; evq.push_back(ev);
            free_cyc = last + 1;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        while (cyc < free_cyc) begin
            start = 1'b0; abort = 1'b0;
            step();
        end
    endtask

    task automatic run_tile(input int k, input int simd, input int abort_off, input bit noise);
        int n, stop;
        wait_idle();
        n = cyc;
        start = 1'b1; k_len = K_W'(k); simd_mode = 2'(simd); abort = 1'b0;
        plan(n, k, simd, abort_off);
        stop = free_cyc;
        step();
        start = 1'b0;
        while (cyc < stop) begin
            abort = (abort_off > 0) && (cyc == n + abort_off);
            if (noise) begin
                start     = ($urandom_range(0, 3) == 0);
                k_len     = K_W'($urandom_range(0, 12));
                simd_mode = 2'($urandom);
                if (abort_off > 0 && cyc > n + abort_off)
                    abort = ($urandom_range(0, 1) == 1);
            end
            step();
        end
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic idle_gap(input int g);
        repeat (g) begin
            abort = ($urandom_range(0, 1) == 1);
            step();
        end
        abort = 1'b0;
    endtask

    // Monitor: sole owner of the check/error counters.
    initial begin : monitor
        frame_t e, a;
        ev_t    ev;
        int     kind;
        bit     in_rst;
        checks = 0; errors = 0; exp_busy_cnt = 0; exp_done_cnt = 0;
        last_simd = '0; in_rst = 1'b1;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                if (!in_rst) begin
                    in_rst = 1'b1;
                    #1;
                    a = sample();
                    checks++;
                    if (a !== '0) begin
                        errors++;
                        $display("FAIL async_reset outputs actual=%h required=0", a);
                    end
`ifdef ARRAY_CTRL_PERF_EN
                    checks++;
                    if (tile_cnt !== 32'd0 || busy_cycles !== 32'd0) begin
                        errors++;
                        $display("FAIL async_reset perf actual=%0d/%0d required=0/0", tile_cnt, busy_cycles);
                    end
`endif
                    exp_fr.delete();
                    evq.delete();
                end
                last_simd = '0; exp_busy_cnt = 0; exp_done_cnt = 0;
            end else begin
                in_rst = 1'b0;
                if (finish_req) begin
                    checks++;
                    if (evq.size() != 0 || exp_fr.num() != 0) begin
                        errors++;
                        $display("FAIL drain pending actual=%0d/%0d required=0/0", evq.size(), exp_fr.num());
                    end
`ifdef ARRAY_CTRL_PERF_EN
                    checks++;
                    if (tile_cnt !== 32'(exp_done_cnt)) begin
                        errors++;
                        $display("FAIL tile_cnt actual=%0d required=%0d", tile_cnt, exp_done_cnt);
                    end
                    checks++;
                    if (busy_cycles !== 32'(exp_busy_cnt)) begin
                        errors++;
                        $display("FAIL busy_cycles actual=%0d required=%0d", busy_cycles, exp_busy_cnt);
                    end
`endif
                    $display("CHECKS %0d ERRORS %0d", checks, errors);
                    $finish;
                end
                if (exp_fr.exists(cyc)) begin
                    e = exp_fr[cyc];
                    exp_fr.delete(cyc);
                end else begin
                    e = '0;
                    e.simd = last_simd;
                end
                last_simd = e.simd;
                a = sample();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL frame cyc=%0d actual=%h required=%h", cyc, a, e);
                end
                if (e.busy) exp_busy_cnt++;
                if (e.done) exp_done_cnt++;
                if (done || aborted || err) begin
                    kind = done ? 0 : (aborted ? 1 : 2);
                    checks++;
                    if (evq.size() == 0) begin
                        errors++;
                        $display("FAIL pulse cyc=%0d actual=kind%0d required=none", cyc, kind);
                    end else begin
                        ev = evq.pop_front();
                        if (ev.kind != kind || ev.cyc != cyc) begin
                            errors++;
                            $display("FAIL pulse actual=kind%0d@%0d required=kind%0d@%0d",
                                     kind, cyc, ev.kind, ev.cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int k, ao, tend;
        start = 1'b0; abort = 1'b0; k_len = '0; simd_mode = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        free_cyc = cyc;
        step();

        run_tile(8, 2, 0, 1'b0);            // baseline K=8
        run_tile(1, 0, 0, 1'b0);            // rejected
        run_tile(2, 3, 0, 1'b0);            // minimum K
        run_tile(5, 1, 0, 1'b1);            // starts while busy
        run_tile(8, 0, 8, 1'b0);            // abort at t=5
        run_tile(8, 2, 0, 1'b0);            // back-to-back pair
        run_tile(8, 1, 0, 1'b0);
        run_tile(3, 2, 1, 1'b0);            // abort in first CLEAR cycle
        run_tile(3, 1, 2, 1'b0);            // abort in second CLEAR cycle
        run_tile(4, 3, 3 + ROWS + COLS - 2 + 4 + DONE_OFS + RES_OFS, 1'b0);  // abort at T_END
        run_tile(0, 0, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 12);
            ao = 0;
            if (k >= 2 && $urandom_range(0, 3) == 0) begin
                tend = ROWS + COLS - 2 + k + DONE_OFS + RES_OFS;
                ao = $urandom_range(1, 3 + tend);
            end
            run_tile(k, $urandom_range(0, 3), ao, 1'b1);
            idle_gap($urandom_range(0, 3));
        end

        // Reset mid-RUN, then confirm a clean tile afterwards.
        wait_idle();
        start = 1'b1; k_len = K_W'(8); simd_mode = 2'd3;
        plan(cyc, 8, 3, 0);
        step();
        start = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        m_simd = '0;
        repeat (3) step();
        rst_n = 1'b1;
        free_cyc = cyc;
        step();
        run_tile(6, 1, 0, 1'b0);
        run_tile(2, 2, 0, 1'b0);

        repeat (5) step();
        finish_req = 1'b1;
    end

endmodule
